// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard bridge: state encodings, default
// ring-buffer addresses (mirrored by the software header) and small helpers.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_REQ    = 3'd1,
        W_RDTAIL = 3'd2,
        W_RDWAIT = 3'd3,
        W_CHECK  = 3'd4,
        W_WRDATA = 3'd5,
        W_WRHEAD = 3'd6
    } wr_state_t;

    localparam logic [31:0] DEF_BUF_BASE  = 32'h0000_1000;
    localparam logic [31:0] DEF_HEAD_ADDR = 32'h0000_0FF8;
    localparam logic [31:0] DEF_TAIL_ADDR = 32'h0000_0FFC;

    // PS/2 uses odd parity across the data byte and the parity bit together
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^{data, par}) == 1'b1;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/ps2_kbd_bridge_if.sv
// Port-B I/O bus between the keyboard bridge (master) and the arbiter/data memory (slave).
interface ps2_kbd_bridge_if;
    logic        io_req;
    logic        io_gnt;
    logic [31:0] io_addr;
    logic        io_wren;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (output io_req, io_addr, io_wren, io_wdata, input io_gnt, io_rdata);
    modport slave  (input io_req, io_addr, io_wren, io_wdata, output io_gnt, io_rdata);
endinterface

// File: rtl/ps2_kbd_bridge_sync_fifo.sv
// Small synchronous FIFO; a push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_bridge.sv
// PS/2 keyboard receiver that appends each scan code to a software-polled ring
// buffer in data memory through the port-B I/O bus.
module ps2_kbd_bridge
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [31:0] BUF_BASE    = DEF_BUF_BASE,
    parameter int unsigned BUF_DEPTH   = 16,
    parameter logic [31:0] HEAD_ADDR   = DEF_HEAD_ADDR,
    parameter logic [31:0] TAIL_ADDR   = DEF_TAIL_ADDR,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    ps2_kbd_bridge_if.master        bus,
    output logic                    frame_err,
    output logic [7:0]              ovf_cnt
);
    localparam int unsigned HW       = $clog2(BUF_DEPTH);
    localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);
    localparam logic [HW-1:0] HEAD_ONE = HW'(1);

    logic [2:0]    clk_sync_r;
    logic [1:0]    dat_sync_r;
    logic          fall_s;
    logic          bit_s;
    rx_state_t     rx_state_r, rx_next_s;
    logic [2:0]    bit_cnt_r, bit_cnt_next_s;
    logic [7:0]    shift_r, shift_next_s;
    logic          par_ok_r, par_ok_next_s;
    logic          push_r, push_next_s;
    logic          err_s, frame_err_r, timeout_s;
    logic [TW-1:0] to_cnt_r;
    logic          fifo_full_s, fifo_empty_s, fifo_drop_s;
    logic [7:0]    fifo_dout_s;
    logic [7:0]    ovf_r;
    wr_state_t     wr_state_r, wr_next_s;
    logic [HW-1:0] head_r, head_next_s, head_inc_s, tail_r, tail_next_s;
    logic          pend_r, pend_next_s, pop_s, ring_drop_s;
    logic          req_s, wren_s;
    logic [31:0]   addr_s, wdata_s;
    logic          rdata_unused_s;

    // Line synchronisers; idle-high reset values keep reset release edge-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_r <= 3'b111;
            dat_sync_r <= 2'b11;
        end else begin
            clk_sync_r <= {clk_sync_r[1:0], ps2_clk};
            dat_sync_r <= {dat_sync_r[0], ps2_data};
        end
    end

    assign fall_s    = clk_sync_r[2] & ~clk_sync_r[1];
    assign bit_s     = dat_sync_r[1];
    assign timeout_s = (rx_state_r != RX_IDLE) && (to_cnt_r == TO_MAX) && !fall_s;

    // Receiver state, shift register, timeout counter and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r  <= RX_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'd0;
            par_ok_r    <= 1'b0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            to_cnt_r    <= '0;
        end else begin
            rx_state_r  <= rx_next_s;
            bit_cnt_r   <= bit_cnt_next_s;
            shift_r     <= shift_next_s;
            par_ok_r    <= par_ok_next_s;
            push_r      <= push_next_s;
            frame_err_r <= err_s;
            if (fall_s) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_MAX) begin
                to_cnt_r <= to_cnt_r + 1'b1;
            end
        end
    end

    // Receiver next state: one step per falling PS/2 clock edge
    always_comb begin
        rx_next_s      = rx_state_r;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        par_ok_next_s  = par_ok_r;
        push_next_s    = 1'b0;
        err_s          = 1'b0;
        if (timeout_s) begin
            rx_next_s = RX_IDLE;
            err_s     = 1'b1;
        end else if (fall_s) begin
            case (rx_state_r)
                RX_IDLE: begin
                    if (!bit_s) begin
                        rx_next_s      = RX_DATA;
                        bit_cnt_next_s = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_next_s   = {bit_s, shift_r[7:1]};
                    bit_cnt_next_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        rx_next_s = RX_PARITY;
                    end else begin
                        rx_next_s = RX_DATA;
                    end
                end
                RX_PARITY: begin
                    par_ok_next_s = odd_parity_ok(shift_r, bit_s);
                    rx_next_s     = RX_STOP;
                end
                RX_STOP: begin
                    rx_next_s = RX_IDLE;
                    if (bit_s && par_ok_r) begin
                        push_next_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: rx_next_s = RX_IDLE;
            endcase
        end else begin
            rx_next_s = rx_state_r;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_r),
        .pop   (pop_s),
        .din   (shift_r),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .dout  (fifo_dout_s)
    );

    assign fifo_drop_s = push_r & fifo_full_s;
    assign head_inc_s  = head_r + HEAD_ONE;

    // Writer state, ring indices and drop counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_r <= W_IDLE;
            head_r     <= '0;
            tail_r     <= '0;
            pend_r     <= 1'b0;
            ovf_r      <= 8'd0;
        end else begin
            wr_state_r <= wr_next_s;
            head_r     <= head_next_s;
            tail_r     <= tail_next_s;
            pend_r     <= pend_next_s;
            ovf_r      <= sat_add8(ovf_r, {1'b0, fifo_drop_s} + {1'b0, ring_drop_s});
        end
    end

    // Writer next state and bus outputs; pend_r marks a data word whose head update is still owed
    always_comb begin
        wr_next_s   = wr_state_r;
        head_next_s = head_r;
        tail_next_s = tail_r;
        pend_next_s = pend_r;
        pop_s       = 1'b0;
        ring_drop_s = 1'b0;
        req_s       = (wr_state_r != W_IDLE);
        wren_s      = 1'b0;
        addr_s      = 32'd0;
        wdata_s     = 32'd0;
        case (wr_state_r)
            W_IDLE: begin
                if (!fifo_empty_s || pend_r) begin
                    wr_next_s = W_REQ;
                end else begin
                    wr_next_s = W_IDLE;
                end
            end
            W_REQ: begin
                if (bus.io_gnt) begin
                    wr_next_s = W_RDTAIL;
                end else begin
                    wr_next_s = W_REQ;
                end
            end
            W_RDTAIL: begin
                addr_s = TAIL_ADDR;
                if (bus.io_gnt) begin
                    wr_next_s = W_RDWAIT;
                end else begin
                    wr_next_s = W_REQ;
                end
            end
            W_RDWAIT: begin
                if (bus.io_gnt) begin
                    tail_next_s = bus.io_rdata[HW-1:0];
                    wr_next_s   = W_CHECK;
                end else begin
                    wr_next_s = W_REQ;
                end
            end
            W_CHECK: begin
                if (!bus.io_gnt) begin
                    wr_next_s = W_REQ;
                end else if (pend_r) begin
                    wr_next_s = W_WRHEAD;
                end else if (head_inc_s == tail_r) begin
                    pop_s       = 1'b1;
                    ring_drop_s = 1'b1;
                    wr_next_s   = W_IDLE;
                end else begin
                    wr_next_s = W_WRDATA;
                end
            end
            W_WRDATA: begin
                if (bus.io_gnt) begin
                    addr_s      = BUF_BASE + {{(30 - HW){1'b0}}, head_r, 2'b00};
                    wdata_s     = {24'd0, fifo_dout_s};
                    wren_s      = 1'b1;
                    pop_s       = 1'b1;
                    pend_next_s = 1'b1;
                    wr_next_s   = W_WRHEAD;
                end else begin
                    wr_next_s = W_REQ;
                end
            end
            W_WRHEAD: begin
                if (bus.io_gnt) begin
                    addr_s      = HEAD_ADDR;
                    wdata_s     = 32'(head_inc_s);
                    wren_s      = 1'b1;
                    head_next_s = head_inc_s;
                    pend_next_s = 1'b0;
                    wr_next_s   = W_IDLE;
                end else begin
                    wr_next_s = W_REQ;
                end
            end
            default: wr_next_s = W_IDLE;
        endcase
    end

    assign rdata_unused_s = ^bus.io_rdata[31:HW];
    assign bus.io_req     = req_s;
    assign bus.io_wren    = wren_s;
    assign bus.io_addr    = addr_s;
    assign bus.io_wdata   = wdata_s;
    assign frame_err      = frame_err_r;
    assign ovf_cnt        = ovf_r;

endmodule
